// File: rtl/power_sequencer_pkg.sv
// Shared definitions for the five-rail power sequencer.
// Holds the rail count, the index width, the FSM state encoding and
// small bit-scan helpers used by the sequencer's next-state logic.
package power_sequencer_pkg;

    localparam int unsigned NUM_RAILS = 5;
    localparam int unsigned IDX_W     = 3;

    typedef logic [NUM_RAILS-1:0] rail_vec_t;
    typedef logic [IDX_W-1:0]     rail_idx_t;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_RAMP     = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_ON       = 3'd3,
        ST_SHUTDOWN = 3'd4,
        ST_FAULT    = 3'd5
    } seq_state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic rail_idx_t lowest_set(input rail_vec_t v);
        rail_idx_t r;
        r = '0;
        for (int unsigned k = NUM_RAILS; k > 0; k--) begin
            if (v[k-1]) r = rail_idx_t'(k - 1);
        end
        return r;
    endfunction

    // Index of the highest set bit; 0 when no bit is set.
    function automatic rail_idx_t highest_set(input rail_vec_t v);
        rail_idx_t r;
        r = '0;
        for (int unsigned k = 0; k < NUM_RAILS; k++) begin
            if (v[k]) r = rail_idx_t'(k);
        end
        return r;
    endfunction

    // Mask of rails below idx, optionally including idx itself.
    function automatic rail_vec_t rails_upto(input rail_idx_t idx, input logic inclusive);
        rail_vec_t m;
        m = '0;
        for (int unsigned k = 0; k < NUM_RAILS; k++) begin
            m[k] = (k < int'(idx)) || (inclusive && (k == int'(idx)));
        end
        return m;
    endfunction

endpackage

// File: rtl/power_sequencer_if.sv
// Bundle of the sequencer's request, power-good and status signals.
//   i_enable       : power-up request level (1 = up, 0 = down / clear fault)
//   i_pgood        : per-rail regulator power-good
//   o_railEn       : per-rail regulator enables
//   o_sequenceDone : all rails up and settled
//   o_fault        : sequencer is latched in FAULT
//   o_faultRail    : index of the rail that caused the fault
//   o_state        : FSM state encoding for debug
// master = host/board side, slave = sequencer side.
interface power_sequencer_if;
    import power_sequencer_pkg::*;

    logic       i_enable;
    rail_vec_t  i_pgood;
    rail_vec_t  o_railEn;
    logic       o_sequenceDone;
    logic       o_fault;
    rail_idx_t  o_faultRail;
    logic [2:0] o_state;

    modport master (
        output i_enable, i_pgood,
        input  o_railEn, o_sequenceDone, o_fault, o_faultRail, o_state
    );

    modport slave (
        input  i_enable, i_pgood,
        output o_railEn, o_sequenceDone, o_fault, o_faultRail, o_state
    );

endinterface

// File: rtl/power_sequencer_seq_timer.sv
// 32-bit loadable up-counter shared by the timeout, settle and off-delay
// intervals of the power sequencer.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear to zero (wins over load/inc)
//   load     : load load_val
//   inc      : count up by one
//   term_val : terminal-count value for the current interval
//   at_term  : count equals term_val
module power_sequencer_seq_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        inc,
    input  logic [31:0] term_val,
    output logic        at_term
);

    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 32'd1;
        end
    end

    assign at_term = (count == term_val);

endmodule

// File: rtl/power_sequencer.sv
// Ordered power-up / power-down controller for five PMIC rails.
// Rails are enabled one at a time, each must report power-good within a
// timeout and stay good for a settle interval before the next one starts.
// Normal power-down disables rails highest first with a fixed spacing;
// any power-good loss drops every rail at once and latches the culprit.
//   i_clk   : system clock
//   i_reset : synchronous active-high reset
//   bus     : request / power-good inputs and registered status outputs
module power_sequencer
    import power_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd100000,
    parameter int unsigned SETTLE_CYCLES  = 32'd1000,
    parameter int unsigned OFF_DELAY      = 32'd1000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    power_sequencer_if.slave bus
);

    seq_state_t  state_q, state_n;
    rail_idx_t   idx_q, idx_n;
    rail_vec_t   rail_en_q, rail_en_n;
    rail_idx_t   fault_rail_q, fault_rail_n;
    logic        done_q, fault_q;

    logic        cnt_clr, cnt_inc, at_term;
    logic [31:0] term_val;
    rail_vec_t   bad;

    power_sequencer_seq_timer u_timer (
        .clk      (i_clk),
        .rst      (i_reset),
        .clr      (cnt_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (cnt_inc),
        .term_val (term_val),
        .at_term  (at_term)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_OFF;
            idx_q        <= '0;
            rail_en_q    <= '0;
            fault_rail_q <= '0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_n;
            idx_q        <= idx_n;
            rail_en_q    <= rail_en_n;
            fault_rail_q <= fault_rail_n;
            done_q       <= (state_n == ST_ON);
            fault_q      <= (state_n == ST_FAULT);
        end
    end

    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        rail_en_n    = rail_en_q;
        fault_rail_n = fault_rail_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        term_val     = '0;
        bad          = '0;

        case (state_q)
            ST_OFF: begin
                if (bus.i_enable) begin
                    state_n   = ST_RAMP;
                    idx_n     = '0;
                    rail_en_n = rail_vec_t'(1);
                    cnt_clr   = 1'b1;
                end
            end

            ST_RAMP: begin
                term_val = TIMEOUT_CYCLES - 32'd1;
                bad      = ~bus.i_pgood & rails_upto(idx_q, 1'b0);
                if (|bad) begin
                    state_n      = ST_FAULT;
                    rail_en_n    = '0;
                    fault_rail_n = lowest_set(bad);
                end else if (!bus.i_pgood[idx_q] && at_term) begin
                    state_n      = ST_FAULT;
                    rail_en_n    = '0;
                    fault_rail_n = idx_q;
                end else if (!bus.i_enable) begin
                    state_n                         = ST_SHUTDOWN;
                    rail_en_n[highest_set(rail_en_q)] = 1'b0;
                    cnt_clr                         = 1'b1;
                end else if (bus.i_pgood[idx_q]) begin
                    state_n = ST_SETTLE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            ST_SETTLE: begin
                term_val = SETTLE_CYCLES - 32'd1;
                bad      = ~bus.i_pgood & rails_upto(idx_q, 1'b1);
                if (|bad) begin
                    state_n      = ST_FAULT;
                    rail_en_n    = '0;
                    fault_rail_n = lowest_set(bad);
                end else if (!bus.i_enable) begin
                    state_n                         = ST_SHUTDOWN;
                    rail_en_n[highest_set(rail_en_q)] = 1'b0;
                    cnt_clr                         = 1'b1;
                end else if (at_term) begin
                    if (idx_q == rail_idx_t'(NUM_RAILS - 1)) begin
                        state_n = ST_ON;
                    end else begin
                        state_n                   = ST_RAMP;
                        idx_n                     = idx_q + 3'd1;
                        rail_en_n[idx_q + 3'd1]   = 1'b1;
                        cnt_clr                   = 1'b1;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            ST_ON: begin
                bad = ~bus.i_pgood;
                if (|bad) begin
                    state_n      = ST_FAULT;
                    rail_en_n    = '0;
                    fault_rail_n = lowest_set(bad);
                end else if (!bus.i_enable) begin
                    state_n                         = ST_SHUTDOWN;
                    rail_en_n[highest_set(rail_en_q)] = 1'b0;
                    cnt_clr                         = 1'b1;
                end
            end

            // Rails are cleared from the live enable vector rather than from
            // idx, so entry from RAMP, SETTLE or ON shares one path.
            ST_SHUTDOWN: begin
                term_val = OFF_DELAY - 32'd1;
                if (rail_en_q == '0) begin
                    state_n = ST_OFF;
                    idx_n   = '0;
                end else if (at_term) begin
                    rail_en_n[highest_set(rail_en_q)] = 1'b0;
                    cnt_clr                         = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            ST_FAULT: begin
                rail_en_n = '0;
                if (!bus.i_enable) begin
                    state_n      = ST_OFF;
                    idx_n        = '0;
                    fault_rail_n = '0;
                end
            end

            default: begin
                state_n   = ST_OFF;
                idx_n     = '0;
                rail_en_n = '0;
            end
        endcase
    end

    assign bus.o_railEn       = rail_en_q;
    assign bus.o_sequenceDone = done_q;
    assign bus.o_fault        = fault_q;
    assign bus.o_faultRail    = fault_rail_q;
    assign bus.o_state        = state_q;

endmodule

// File: tb/tb_power_sequencer.sv
// Scoreboard bench for power_sequencer: a board-level pgood plant reacts to
// the expected rail enables, a count-based reference model predicts the
// registered outputs for every cycle, and a monitor compares them.
module tb_power_sequencer;

    localparam int TO = 20;
    localparam int ST = 4;
    localparam int OD = 3;

    typedef struct packed {
        logic [4:0] en;
        logic       done;
        logic       flt;
        logic [2:0] frail;
        logic [2:0] st;
    } exp_t;

    logic clk;
    logic rst;
    power_sequencer_if bus ();

    power_sequencer #(
        .TIMEOUT_CYCLES (TO),
        .SETTLE_CYCLES  (ST),
        .OFF_DELAY      (OD)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    exp_t mx;
    int   vectors;
    int   miscompares;

    // Reference model: phase 0..5 = off, ramp, settle, on, shutdown, fault.
    // Enabled rails are tracked as a count n (rails 0..n-1 on).
    int m_phase, m_n, m_t, m_frail;

    // Pgood plant: a rail reports good once enabled for `rise` cycles,
    // unless stuck low or deliberately dropped.
    int         rise;
    logic [4:0] stuck, drop;
    int         age [5];

    function automatic logic [4:0] rails(input int n);
        logic [5:0] v;
        v = 6'((1 << n) - 1);
        return v[4:0];
    endfunction

    // Lowest j < limit with p[j] low, or -1.
    function automatic int first_low(input logic [4:0] p, input int limit);
        for (int j = 0; j < limit; j++) if (!p[j]) return j;
        return -1;
    endfunction

    task automatic go_fault(input int j);
        m_phase = 5; m_n = 0; m_frail = j;
    endtask

    task automatic go_shutdown();
        m_phase = 4; m_n = m_n - 1; m_t = 0;
    endtask

    task automatic model_step(input logic r, input logic e, input logic [4:0] p);
        int cur, b;
        if (r) begin
            m_phase = 0; m_n = 0; m_t = 0; m_frail = 0;
            return;
        end
        cur = m_n - 1;
        case (m_phase)
            0: if (e) begin m_phase = 1; m_n = 1; m_t = 0; end
            1: begin
                b = first_low(p, cur);
                if (b >= 0) go_fault(b);
                else if (!p[cur] && m_t == TO - 1) go_fault(cur);
                else if (!e) go_shutdown();
                else if (p[cur]) begin m_phase = 2; m_t = 0; end
                else m_t++;
            end
            2: begin
                b = first_low(p, cur + 1);
                if (b >= 0) go_fault(b);
                else if (!e) go_shutdown();
                else if (m_t == ST - 1) begin
                    if (m_n == 5) m_phase = 3;
                    else begin m_phase = 1; m_n++; m_t = 0; end
                end else m_t++;
            end
            3: begin
                b = first_low(p, 5);
                if (b >= 0) go_fault(b);
                else if (!e) go_shutdown();
            end
            4: begin
                if (m_n == 0) m_phase = 0;
                else if (m_t == OD - 1) begin m_n--; m_t = 0; end
                else m_t++;
            end
            default: if (!e) begin m_phase = 0; m_frail = 0; end
        endcase
    endtask

    // One clock of stimulus: drive inputs at the falling edge, predict the
    // outputs that follow the next rising edge and queue them.
    task automatic cycle(input logic e, input logic r);
        logic [4:0] cur, pg;
        exp_t x;
        @(negedge clk);
        cur = rails(m_n);
        for (int k = 0; k < 5; k++)
            pg[k] = cur[k] && (age[k] >= rise) && !stuck[k] && !drop[k];
        rst          = r;
        bus.i_enable = e;
        bus.i_pgood  = pg;
        model_step(r, e, pg);
        x.en    = rails(m_n);
        x.done  = (m_phase == 3);
        x.flt   = (m_phase == 5);
        x.frail = 3'(m_frail);
        x.st    = 3'(m_phase);
        q.push_back(x);
        cur = rails(m_n);
        for (int k = 0; k < 5; k++) age[k] = cur[k] ? age[k] + 1 : 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mx = q.pop_front();
            vectors++;
            if (bus.o_railEn !== mx.en || bus.o_sequenceDone !== mx.done ||
                bus.o_fault !== mx.flt || bus.o_faultRail !== mx.frail ||
                bus.o_state !== mx.st) begin
                miscompares++;
                $display("FAIL vec%0d @%0t: got railEn=%b done=%b fault=%b faultRail=%0d state=%0d, expected railEn=%b done=%b fault=%b faultRail=%0d state=%0d",
                         vectors, $time, bus.o_railEn, bus.o_sequenceDone, bus.o_fault,
                         bus.o_faultRail, bus.o_state, mx.en, mx.done, mx.flt, mx.frail, mx.st);
            end
        end
    end

    initial begin
        logic ren;
        vectors = 0; miscompares = 0;
        m_phase = 0; m_n = 0; m_t = 0; m_frail = 0;
        rise = 5; stuck = '0; drop = '0;
        for (int k = 0; k < 5; k++) age[k] = 0;
        rst = 1'b1; bus.i_enable = 1'b0; bus.i_pgood = '0;

        // reset state
        repeat (2) cycle(1'b0, 1'b1);

        // nominal power-up to ON
        repeat (60) cycle(1'b1, 1'b0);

        // rails 1 and 3 lost together in ON: lowest reported
        drop = 5'b01010;
        cycle(1'b1, 1'b0);
        drop = '0;
        repeat (3) cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);

        // rail 2 never good: timeout, FAULT held while enabled, then cleared
        stuck = 5'b00100;
        repeat (60) cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);
        stuck = '0;

        // ordered shutdown with pgood drops and enable re-assertion mid-way
        repeat (60) cycle(1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b0);
        drop = 5'b00011;
        repeat (3) cycle(1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);
        drop = '0;
        repeat (10) cycle(1'b1, 1'b0);
        repeat (40) cycle(1'b0, 1'b0);

        // enable drop while ramping rail 2
        stuck = 5'b00100;
        for (int i = 0; i < 300 && !(m_phase == 1 && m_n == 3); i++) cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);
        repeat (20) cycle(1'b0, 1'b0);
        stuck = '0;

        // reset while settling rail 3, then restart with enable held
        for (int i = 0; i < 300 && !(m_phase == 2 && m_n == 4); i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        repeat (60) cycle(1'b1, 1'b0);

        // randomized operation
        ren = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 79) == 0) ren = ~ren;
            if ($urandom_range(0, 149) == 0) drop = 5'(1 << $urandom_range(0, 4));
            else if ($urandom_range(0, 19) == 0) drop = '0;
            if ($urandom_range(0, 59) == 0) rise = $urandom_range(0, 25);
            cycle(ren, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
        end

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
